// File: rtl/eu_operand_fetch_pkg.sv
// Shared types and widths for the EU operand-fetch stage.
package eu_operand_fetch_pkg;

    localparam int unsigned DATA_WIDTH          = 16;
    localparam int unsigned TAG_WIDTH           = 8;
    localparam int unsigned OPCODE_WIDTH        = 4;
    localparam int unsigned IMM_WIDTH           = 8;
    localparam int unsigned NUM_EXEC_UNITS      = 4;
    localparam int unsigned LOG2_NUM_EXEC_UNITS = $clog2(NUM_EXEC_UNITS);

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [TAG_WIDTH-1:0]    dest_tag;
        logic [TAG_WIDTH-1:0]    src_a_tag;
        logic [TAG_WIDTH-1:0]    src_b_tag;
        logic                    src_b_is_imm;
        logic [IMM_WIDTH-1:0]    imm;
    } type_iqueue_entry;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [DATA_WIDTH-1:0]   a;
        logic [DATA_WIDTH-1:0]   b;
        logic [TAG_WIDTH-1:0]    dest_tag;
    } type_alu_packet;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } type_opfetch_state;

    // Immediates are unsigned and zero-extended into the operand datapath.
    function automatic logic [DATA_WIDTH-1:0] imm_to_data(input logic [IMM_WIDTH-1:0] imm);
        return DATA_WIDTH'(imm);
    endfunction

endpackage

// File: rtl/eu_operand_fetch_if.sv
// Bus bundle between the operand-fetch stage, the instruction queue,
// the operand network and the ALU. master = fetch stage side.
interface eu_operand_fetch_if
    import eu_operand_fetch_pkg::*;
#(
    parameter int unsigned STALL_CTR_WIDTH = 16
);
    type_iqueue_entry                 instr_i;
    logic                             instr_valid_i;
    logic                             instr_ready_o;
    logic                             req_a_valid_o;
    logic [TAG_WIDTH-1:0]             req_a_tag_o;
    logic                             rsp_a_valid_i;
    logic [DATA_WIDTH-1:0]            rsp_a_data_i;
    logic                             req_b_valid_o;
    logic [TAG_WIDTH-1:0]             req_b_tag_o;
    logic                             rsp_b_valid_i;
    logic [DATA_WIDTH-1:0]            rsp_b_data_i;
    logic [LOG2_NUM_EXEC_UNITS-1:0]   req_euidx_o;
    logic                             alu_valid_o;
    logic                             alu_ready_i;
    logic [OPCODE_WIDTH-1:0]          alu_opcode_o;
    logic [DATA_WIDTH-1:0]            alu_a_o;
    logic [DATA_WIDTH-1:0]            alu_b_o;
    logic [TAG_WIDTH-1:0]             alu_dest_tag_o;
    logic [STALL_CTR_WIDTH-1:0]       stall_cycles_o;

    modport master (
        input  instr_i, instr_valid_i, rsp_a_valid_i, rsp_a_data_i,
               rsp_b_valid_i, rsp_b_data_i, alu_ready_i,
        output instr_ready_o, req_a_valid_o, req_a_tag_o, req_b_valid_o, req_b_tag_o,
               req_euidx_o, alu_valid_o, alu_opcode_o, alu_a_o, alu_b_o,
               alu_dest_tag_o, stall_cycles_o
    );

    modport slave (
        output instr_i, instr_valid_i, rsp_a_valid_i, rsp_a_data_i,
               rsp_b_valid_i, rsp_b_data_i, alu_ready_i,
        input  instr_ready_o, req_a_valid_o, req_a_tag_o, req_b_valid_o, req_b_tag_o,
               req_euidx_o, alu_valid_o, alu_opcode_o, alu_a_o, alu_b_o,
               alu_dest_tag_o, stall_cycles_o
    );
endinterface

// File: rtl/eu_operand_fetch_slot.sv
// One operand slot: outstanding-request flag, request tag and captured data.
module eu_operand_fetch_slot
    import eu_operand_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  load_need,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [TAG_WIDTH-1:0]  load_tag,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  need,
    output logic [DATA_WIDTH-1:0] data,
    output logic [TAG_WIDTH-1:0]  tag,
    output logic                  present_c
);

    // Present once nothing is outstanding or the response lands this cycle.
    assign present_c = ~need | rsp_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            need <= 1'b0;
            data <= '0;
            tag  <= '0;
        end else if (load) begin
            need <= load_need;
            tag  <= load_tag;
            if (!load_need) begin
                data <= load_data;
            end
        end else if (need && rsp_valid) begin
            need <= 1'b0;
            data <= rsp_data;
        end
    end

endmodule

// File: rtl/eu_operand_fetch.sv
// EU operand fetch: pops the instruction queue, gathers operands from the
// operand network (or immediate) and hands a full packet to the ALU.
module eu_operand_fetch
    import eu_operand_fetch_pkg::*;
#(
    parameter int unsigned STALL_CTR_WIDTH = 16,
    parameter int unsigned EU_IDX          = 0
)(
    input  logic               clk,
    input  logic               reset_n,
    eu_operand_fetch_if.master bus
);

    type_opfetch_state           state_q, state_d;
    logic                        instr_ready_c, alu_valid_c, pop_c;
    logic                        a_present_c, b_present_c, operands_done_c;
    logic                        need_a, need_b;
    logic [DATA_WIDTH-1:0]       data_a, data_b;
    logic [TAG_WIDTH-1:0]        tag_a, tag_b;
    logic [OPCODE_WIDTH-1:0]     opcode_q;
    logic [TAG_WIDTH-1:0]        dest_q;
    logic [STALL_CTR_WIDTH-1:0]  stall_q;
    type_alu_packet              alu_pkt_c;

    assign operands_done_c = a_present_c & b_present_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.instr_valid_i) state_d = FETCH;
            FETCH:   if (operands_done_c) state_d = ISSUE;
            ISSUE:   if (bus.alu_ready_i) state_d = bus.instr_valid_i ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ISSUE accepts the next instruction in the same cycle the ALU takes the packet.
    always_comb begin
        instr_ready_c = 1'b0;
        alu_valid_c   = 1'b0;
        case (state_q)
            IDLE:  instr_ready_c = 1'b1;
            ISSUE: begin
                alu_valid_c   = 1'b1;
                instr_ready_c = bus.alu_ready_i;
            end
            default: ;
        endcase
    end

    assign pop_c = instr_ready_c & bus.instr_valid_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= '0;
            dest_q   <= '0;
        end else if (pop_c) begin
            opcode_q <= bus.instr_i.opcode;
            dest_q   <= bus.instr_i.dest_tag;
        end
    end

    // Saturating count of FETCH cycles still waiting on an operand.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (state_q == FETCH && !operands_done_c && stall_q != '1) begin
            stall_q <= stall_q + STALL_CTR_WIDTH'(1);
        end
    end

    eu_operand_fetch_slot u_slot_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (pop_c),
        .load_need (1'b1),
        .load_data ('0),
        .load_tag  (bus.instr_i.src_a_tag),
        .rsp_valid (bus.rsp_a_valid_i),
        .rsp_data  (bus.rsp_a_data_i),
        .need      (need_a),
        .data      (data_a),
        .tag       (tag_a),
        .present_c (a_present_c)
    );

    eu_operand_fetch_slot u_slot_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (pop_c),
        .load_need (~bus.instr_i.src_b_is_imm),
        .load_data (imm_to_data(bus.instr_i.imm)),
        .load_tag  (bus.instr_i.src_b_tag),
        .rsp_valid (bus.rsp_b_valid_i),
        .rsp_data  (bus.rsp_b_data_i),
        .need      (need_b),
        .data      (data_b),
        .tag       (tag_b),
        .present_c (b_present_c)
    );

    assign alu_pkt_c = '{opcode: opcode_q, a: data_a, b: data_b, dest_tag: dest_q};

    assign bus.instr_ready_o  = instr_ready_c;
    assign bus.req_a_valid_o  = need_a;
    assign bus.req_a_tag_o    = tag_a;
    assign bus.req_b_valid_o  = need_b;
    assign bus.req_b_tag_o    = tag_b;
    assign bus.req_euidx_o    = LOG2_NUM_EXEC_UNITS'(EU_IDX);
    assign bus.alu_valid_o    = alu_valid_c;
    assign bus.alu_opcode_o   = alu_pkt_c.opcode;
    assign bus.alu_a_o        = alu_pkt_c.a;
    assign bus.alu_b_o        = alu_pkt_c.b;
    assign bus.alu_dest_tag_o = alu_pkt_c.dest_tag;
    assign bus.stall_cycles_o = stall_q;

endmodule

// File: tb/tb_eu_operand_fetch.sv
// Directed bench for eu_operand_fetch: vector table plus hand-written corner sequences.
module tb_eu_operand_fetch;
    import eu_operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    eu_operand_fetch_if #(.STALL_CTR_WIDTH(16)) bus ();
    eu_operand_fetch_if #(.STALL_CTR_WIDTH(4))  bus4 ();

    eu_operand_fetch #(.STALL_CTR_WIDTH(16), .EU_IDX(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    eu_operand_fetch #(.STALL_CTR_WIDTH(4), .EU_IDX(0)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );

    assign bus4.instr_i       = bus.instr_i;
    assign bus4.instr_valid_i = bus.instr_valid_i;
    assign bus4.rsp_a_valid_i = bus.rsp_a_valid_i;
    assign bus4.rsp_a_data_i  = bus.rsp_a_data_i;
    assign bus4.rsp_b_valid_i = bus.rsp_b_valid_i;
    assign bus4.rsp_b_data_i  = bus.rsp_b_data_i;
    assign bus4.alu_ready_i   = bus.alu_ready_i;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  ta;
        logic [7:0]  tb;
        logic [7:0]  dest;
        logic        imm_en;
        logic [7:0]  imm;
        logic [15:0] a_data;
        logic [15:0] b_data;
        int          a_dly;
        int          b_dly;
        logic [15:0] exp_b;
        int          exp_stall;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        bus.instr_i       = '0;
        bus.instr_valid_i = 1'b0;
        bus.rsp_a_valid_i = 1'b0;
        bus.rsp_a_data_i  = '0;
        bus.rsp_b_valid_i = 1'b0;
        bus.rsp_b_data_i  = '0;
        bus.alu_ready_i   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [7:0] ta, input logic [7:0] tb,
                             input logic [7:0] dest, input logic imm_en, input logic [7:0] imm);
        bus.instr_i.opcode       = op;
        bus.instr_i.src_a_tag    = ta;
        bus.instr_i.src_b_tag    = tb;
        bus.instr_i.dest_tag     = dest;
        bus.instr_i.src_b_is_imm = imm_en;
        bus.instr_i.imm          = imm;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  fetch;
        bit  done;
        do_reset();
        set_instr(v.op, v.ta, v.tb, v.dest, v.imm_en, v.imm);
        bus.instr_valid_i = 1'b1;
        bus.alu_ready_i   = 1'b1;
        #1 check($sformatf("v%0d idle_ready", idx), 32'(bus.instr_ready_o), 32'd1);
        @(posedge clk);
        #1 bus.instr_valid_i = 1'b0;
        fetch = 0;
        done  = 1'b0;
        while (!done && fetch < 40) begin
            bus.rsp_a_valid_i = (fetch == v.a_dly);
            bus.rsp_a_data_i  = v.a_data;
            // for an immediate, a spurious B response must be ignored
            bus.rsp_b_valid_i = v.imm_en ? (fetch == 0) : (fetch == v.b_dly);
            bus.rsp_b_data_i  = v.imm_en ? 16'hDEAD : v.b_data;
            #1;
            check($sformatf("v%0d fetch%0d instr_ready", idx, fetch), 32'(bus.instr_ready_o), 32'd0);
            check($sformatf("v%0d fetch%0d req_a", idx, fetch), 32'(bus.req_a_valid_o),
                  32'(fetch <= v.a_dly));
            check($sformatf("v%0d fetch%0d req_b", idx, fetch), 32'(bus.req_b_valid_o),
                  32'(!v.imm_en && fetch <= v.b_dly));
            if (bus.req_a_valid_o)
                check($sformatf("v%0d fetch%0d tag_a", idx, fetch), 32'(bus.req_a_tag_o), 32'(v.ta));
            if (bus.req_b_valid_o)
                check($sformatf("v%0d fetch%0d tag_b", idx, fetch), 32'(bus.req_b_tag_o), 32'(v.tb));
            @(posedge clk);
            #1;
            bus.rsp_a_valid_i = 1'b0;
            bus.rsp_b_valid_i = 1'b0;
            fetch++;
            if (bus.alu_valid_o) done = 1'b1;
        end
        check($sformatf("v%0d alu_valid_seen", idx), 32'(done), 32'd1);
        check($sformatf("v%0d fetch_cycles", idx), 32'(fetch), 32'(v.exp_stall + 1));
        #1;
        check($sformatf("v%0d alu_a", idx), 32'(bus.alu_a_o), 32'(v.a_data));
        check($sformatf("v%0d alu_b", idx), 32'(bus.alu_b_o), 32'(v.exp_b));
        check($sformatf("v%0d alu_op", idx), 32'(bus.alu_opcode_o), 32'(v.op));
        check($sformatf("v%0d alu_dest", idx), 32'(bus.alu_dest_tag_o), 32'(v.dest));
        check($sformatf("v%0d stall", idx), 32'(bus.stall_cycles_o), 32'(v.exp_stall));
        check($sformatf("v%0d issue_ready", idx), 32'(bus.instr_ready_o), 32'd1);
        @(posedge clk);
        #1;
        check($sformatf("v%0d back_idle_valid", idx), 32'(bus.alu_valid_o), 32'd0);
        check($sformatf("v%0d back_idle_ready", idx), 32'(bus.instr_ready_o), 32'd1);
    endtask

    initial begin
        vecs[0] = '{op:4'd3, ta:8'd5, tb:8'd9, dest:8'd12, imm_en:1'b0, imm:8'h00,
                    a_data:16'h1111, b_data:16'h2222, a_dly:0, b_dly:0, exp_b:16'h2222, exp_stall:0};
        vecs[1] = '{op:4'd7, ta:8'd1, tb:8'd0, dest:8'd20, imm_en:1'b1, imm:8'h7F,
                    a_data:16'hABCD, b_data:16'h0000, a_dly:3, b_dly:0, exp_b:16'h007F, exp_stall:3};
        vecs[2] = '{op:4'hA, ta:8'h21, tb:8'h42, dest:8'h33, imm_en:1'b0, imm:8'h00,
                    a_data:16'h5A5A, b_data:16'hC3C3, a_dly:4, b_dly:1, exp_b:16'hC3C3, exp_stall:4};
        vecs[3] = '{op:4'd1, ta:8'h80, tb:8'hFE, dest:8'h01, imm_en:1'b0, imm:8'h00,
                    a_data:16'hFFFF, b_data:16'h8001, a_dly:0, b_dly:2, exp_b:16'h8001, exp_stall:2};
        vecs[4] = '{op:4'hF, ta:8'h0F, tb:8'h00, dest:8'hFF, imm_en:1'b1, imm:8'hFF,
                    a_data:16'h0000, b_data:16'h0000, a_dly:0, b_dly:0, exp_b:16'h00FF, exp_stall:0};

        // reset values
        clear_inputs();
        #2;
        check("rst instr_ready", 32'(bus.instr_ready_o), 32'd1);
        check("rst req_a", 32'(bus.req_a_valid_o), 32'd0);
        check("rst req_b", 32'(bus.req_b_valid_o), 32'd0);
        check("rst alu_valid", 32'(bus.alu_valid_o), 32'd0);
        check("rst alu_a", 32'(bus.alu_a_o), 32'd0);
        check("rst stall", 32'(bus.stall_cycles_o), 32'd0);
        check("rst euidx", 32'(bus.req_euidx_o), 32'd2);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // ALU backpressure, then back-to-back pop straight into FETCH
        do_reset();
        set_instr(4'd5, 8'd3, 8'd4, 8'd7, 1'b0, 8'h00);
        bus.instr_valid_i = 1'b1;
        bus.alu_ready_i   = 1'b0;
        @(posedge clk);
        #1;
        set_instr(4'd9, 8'h55, 8'h66, 8'h77, 1'b0, 8'h00);
        bus.rsp_a_valid_i = 1'b1; bus.rsp_a_data_i = 16'h0A0A;
        bus.rsp_b_valid_i = 1'b1; bus.rsp_b_data_i = 16'h0B0B;
        @(posedge clk);
        #1;
        bus.rsp_a_valid_i = 1'b0;
        bus.rsp_b_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp%0d alu_valid", c), 32'(bus.alu_valid_o), 32'd1);
            check($sformatf("bp%0d alu_a", c), 32'(bus.alu_a_o), 32'h0A0A);
            check($sformatf("bp%0d alu_b", c), 32'(bus.alu_b_o), 32'h0B0B);
            check($sformatf("bp%0d alu_op", c), 32'(bus.alu_opcode_o), 32'd5);
            check($sformatf("bp%0d alu_dest", c), 32'(bus.alu_dest_tag_o), 32'd7);
            check($sformatf("bp%0d instr_ready", c), 32'(bus.instr_ready_o), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.alu_ready_i = 1'b1;
        #1 check("b2b same_cycle_ready", 32'(bus.instr_ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.instr_valid_i = 1'b0;
        #1;
        check("b2b fetch alu_valid", 32'(bus.alu_valid_o), 32'd0);
        check("b2b fetch instr_ready", 32'(bus.instr_ready_o), 32'd0);
        check("b2b fetch req_a", 32'(bus.req_a_valid_o), 32'd1);
        check("b2b fetch tag_a", 32'(bus.req_a_tag_o), 32'h55);
        check("b2b fetch tag_b", 32'(bus.req_b_tag_o), 32'h66);
        bus.rsp_a_valid_i = 1'b1; bus.rsp_a_data_i = 16'h1234;
        bus.rsp_b_valid_i = 1'b1; bus.rsp_b_data_i = 16'h4321;
        @(posedge clk);
        #1;
        bus.rsp_a_valid_i = 1'b0;
        bus.rsp_b_valid_i = 1'b0;
        #1;
        check("b2b issue alu_valid", 32'(bus.alu_valid_o), 32'd1);
        check("b2b issue alu_a", 32'(bus.alu_a_o), 32'h1234);
        check("b2b issue alu_b", 32'(bus.alu_b_o), 32'h4321);
        check("b2b issue alu_op", 32'(bus.alu_opcode_o), 32'd9);
        check("b2b issue alu_dest", 32'(bus.alu_dest_tag_o), 32'h77);
        check("b2b stall", 32'(bus.stall_cycles_o), 32'd0);
        @(posedge clk);
        #1 check("b2b idle", 32'(bus.alu_valid_o), 32'd0);

        // async reset mid-FETCH, then a stale response in IDLE
        do_reset();
        set_instr(4'd2, 8'h11, 8'h12, 8'h13, 1'b0, 8'h00);
        bus.instr_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid_i = 1'b0;
        @(posedge clk);
        #1 check("mid req_a before reset", 32'(bus.req_a_valid_o), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid rst req_a", 32'(bus.req_a_valid_o), 32'd0);
        check("mid rst req_b", 32'(bus.req_b_valid_o), 32'd0);
        check("mid rst tag_a", 32'(bus.req_a_tag_o), 32'd0);
        check("mid rst instr_ready", 32'(bus.instr_ready_o), 32'd1);
        check("mid rst stall", 32'(bus.stall_cycles_o), 32'd0);
        check("mid rst alu_op", 32'(bus.alu_opcode_o), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.rsp_a_valid_i = 1'b1; bus.rsp_a_data_i = 16'h9999;
        bus.rsp_b_valid_i = 1'b1; bus.rsp_b_data_i = 16'h8888;
        @(posedge clk);
        #1;
        bus.rsp_a_valid_i = 1'b0;
        bus.rsp_b_valid_i = 1'b0;
        #1;
        check("stale alu_a", 32'(bus.alu_a_o), 32'd0);
        check("stale alu_b", 32'(bus.alu_b_o), 32'd0);
        check("stale alu_valid", 32'(bus.alu_valid_o), 32'd0);
        check("stale instr_ready", 32'(bus.instr_ready_o), 32'd1);
        check("stale req_a", 32'(bus.req_a_valid_o), 32'd0);

        // stall counter saturation on the 4-bit instance
        do_reset();
        set_instr(4'd4, 8'h01, 8'h02, 8'h03, 1'b0, 8'h00);
        bus.instr_valid_i = 1'b1;
        bus.alu_ready_i   = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("sat small stall", 32'(bus4.stall_cycles_o), 32'd15);
        check("sat wide stall", 32'(bus.stall_cycles_o), 32'd20);
        check("sat req_a held", 32'(bus.req_a_valid_o), 32'd1);
        bus.rsp_a_valid_i = 1'b1; bus.rsp_a_data_i = 16'h0101;
        bus.rsp_b_valid_i = 1'b1; bus.rsp_b_data_i = 16'h0202;
        @(posedge clk);
        #1;
        bus.rsp_a_valid_i = 1'b0;
        bus.rsp_b_valid_i = 1'b0;
        #1;
        check("sat issue valid", 32'(bus4.alu_valid_o), 32'd1);
        check("sat small stall after", 32'(bus4.stall_cycles_o), 32'd15);
        check("sat wide stall after", 32'(bus.stall_cycles_o), 32'd20);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/eu_operand_fetch.md
Name: eu_operand_fetch

Overview:
- Per-execution-unit stage directly downstream of the EU instruction queue.
- Pops one type_iqueue_entry at a time and requests its source operands from the shared operand network. Operand A always comes from the network; operand B comes from the network or from the immediate.
- Captures the responses and presents a complete {opcode, a, b, dest} packet to the EU ALU with a valid/ready handshake.
- Drives the ready input of the instruction queue.

Parameters:
- DATA_WIDTH, 16, operand/result width.
- TAG_WIDTH, 8, physical register tag width.
- OPCODE_WIDTH, 4, ALU opcode width.
- STALL_CTR_WIDTH, 16, width of the saturating stall counter.
- EU_IDX, 0, this unit's index; tags every operand request.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- instr_i  in  $bits(type_iqueue_entry)  instruction at the head of the queue.
- instr_valid_i  in  1  head is valid.
- instr_ready_o  out  1  pop/accept; the queue dequeues on instr_ready_o & instr_valid_i.
- req_a_valid_o  out  1  operand A read request.
- req_a_tag_o  out  TAG_WIDTH  operand A register tag.
- rsp_a_valid_i  in  1  operand A data returned.
- rsp_a_data_i  in  DATA_WIDTH  operand A data.
- req_b_valid_o  out  1  operand B read request.
- req_b_tag_o  out  TAG_WIDTH  operand B register tag.
- rsp_b_valid_i  in  1  operand B data returned.
- rsp_b_data_i  in  DATA_WIDTH  operand B data.
- req_euidx_o  out  LOG2_NUM_EXEC_UNITS  constant EU_IDX.
- alu_valid_o  out  1  packet valid.
- alu_ready_i  in  1  ALU accepts packet.
- alu_opcode_o  out  OPCODE_WIDTH  opcode.
- alu_a_o  out  DATA_WIDTH  operand A.
- alu_b_o  out  DATA_WIDTH  operand B.
- alu_dest_tag_o  out  TAG_WIDTH  destination tag.
- stall_cycles_o  out  STALL_CTR_WIDTH  saturating count of cycles spent in FETCH waiting for an operand.

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous, active-low.
- Reset values: all registers clear, state=IDLE.
  - instr_ready_o=1 (combinational from state), req_*_valid_o=0, alu_valid_o=0.
  - All data/tag outputs 0; stall_cycles_o=0.
  - Reset mid-FETCH or mid-ISSUE discards the held instruction; no response is expected afterwards.
  - A late rsp_*_valid_i in IDLE is ignored.
- FSM states: IDLE, FETCH, ISSUE.
- IDLE:
  - instr_ready_o=1.
  - On instr_valid_i: latch opcode, dest, src_a_tag, src_b_tag, src_b_is_imm, imm.
  - Set need_a=1 and need_b=~src_b_is_imm; if src_b_is_imm, b_reg=imm (zero-extended to DATA_WIDTH).
  - Next state = FETCH.
- FETCH:
  - req_a_valid_o=need_a; req_b_valid_o=need_b. Tags come from latched fields and are held stable while the request is high.
  - rsp_a_valid_i while need_a: capture into a_reg, clear need_a. Same for B.
  - Both responses may arrive in the same cycle, in either order, or in the first FETCH cycle (zero wait). A response for an operand not requested is ignored.
  - When (need_a & ~rsp_a) | (need_b & ~rsp_b) is false at the clock edge, go to ISSUE. Minimum FETCH residency is 1 cycle.
  - stall_cycles_o increments on every FETCH cycle where that condition is true; it saturates at all-ones and never wraps.
- ISSUE:
  - alu_valid_o=1 with registered a_reg/b_reg/opcode/dest; outputs are stable until handshake.
  - alu_ready_i=0: hold.
  - alu_ready_i=1: packet transfers, and instr_ready_o=1 in the same cycle (back-to-back accept).
    - If instr_valid_i, latch the new instruction and go to FETCH.
    - Otherwise go to IDLE.
- instr_ready_o = (state==IDLE) | (state==ISSUE & alu_ready_i). It is 0 throughout FETCH.
- Throughput: 1 instruction per 2 cycles at best (FETCH + ISSUE), with zero-wait responses and alu_ready_i=1.
- Latency: pop at cycle t → alu_valid_o at t+2 with zero-wait operands.
- Handshake rules:
  - alu_valid_o never deasserts without alu_ready_i.
  - Request valids never deassert before the matching response.
- Immediate B: req_b_valid_o stays 0 for the whole instruction.

Decomposition:
- pkg_dtypes gains or confirms:
  - type_iqueue_entry fields: opcode, dest_tag, src_a_tag, src_b_tag, src_b_is_imm, imm.
  - type_alu_packet {opcode, a, b, dest_tag}.
  - enum type_opfetch_state {IDLE, FETCH, ISSUE}.
  - LOG2_NUM_EXEC_UNITS.
- One natural sub-module: eu_operand_slot, instantiated twice (A and B).
  - Holds the need flag, data register and request/response capture.
  - Signals "ready" when its operand is present.

Test Plan:
- Zero-wait, reg/reg:
  - Stimulus: instr {op=3, a=tag5, b=tag9, dest=12}; rsp_a=0x1111 and rsp_b=0x2222 returned in the first FETCH cycle; alu_ready_i=1.
  - Required: alu_valid_o at pop+2 with a=0x1111, b=0x2222, op=3, dest=12; stall_cycles_o=0.
- Immediate B:
  - Stimulus: src_b_is_imm=1, imm=0x7F; A response after 3 cycles.
  - Required: req_b_valid_o never asserted; b=0x007F; stall_cycles_o=3; instr_ready_o=0 during FETCH.
- Out-of-order responses:
  - Stimulus: B returns at FETCH cycle 1, A at cycle 4.
  - Required: each request drops only after its own response; packet carries the correct data; stall=4.
- ALU backpressure:
  - Stimulus: alu_ready_i=0 for 5 cycles in ISSUE.
  - Required: outputs stable, instr_ready_o=0. When ready rises with the next instr valid: same-cycle pop and direct ISSUE→FETCH transition.
- Async reset mid-FETCH:
  - Stimulus: deassert reset_n between clock edges while req_a_valid_o=1; a stale rsp_a arrives in IDLE.
  - Required: all outputs immediately at reset values; the stale response is ignored.
- Stall saturation:
  - Stimulus: STALL_CTR_WIDTH=4; withhold responses for 20 cycles.
  - Required: stall_cycles_o holds at 15.
